issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Issue controller between the fetch unit and the decode stage (`decodeAndFetchOperands`) of the 3-stage pipeline.
- Keeps a per-register in-use scoreboard and generates the `inuse1`/`inuse2` flags the decoder consumes.
- Decides each cycle whether the instruction presented to decode may issue, or must stall on:
  - a RAW/WAW hazard, or
  - a busy multi-cycle execute or memory operation.
- Clears scoreboard entries on writeback and supports a pipeline flush.

Parameters:
- MUL_OPCODE, 4'b0011, opcode treated as multi-cycle multiply.
- MUL_LAT, 3, execute occupancy in cycles of MUL_OPCODE (legal 1..15).
- MEM_LAT, 2, execute occupancy in cycles of LOAD (4'b1110) (legal 1..15).

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  one clock; reset is asynchronous and active-low
- dec_valid  input  1  dec_instr holds a valid instruction
- dec_instr  input  16  instruction presented to decode
- wb_valid  input  1  writeback of wb_reg this cycle
- wb_reg  input  4  register being written back
- flush  input  1  synchronous pipeline flush
- stall  output  1  hold fetch/decode this cycle (combinational)
- issue  output  1  instruction issues this cycle (combinational)
- inuse1  output  1  source 1 of dec_instr is pending (to decoder)
- inuse2  output  1  source 2 of dec_instr is pending (to decoder)
- ex_busy  output  1  multi-cycle operation occupying execute
- busy_vec  output  16  scoreboard, bit n = Rn pending write
- stall_cycles  output  16  stall statistic (only with STALL_STAT_EN)

Behaviour:
- Field decode of dec_instr, op = [15:12]:
  - LOAD (1110): dest=[3:0]; no sources.
  - STORE (1111): src1=[3:0]; no src2; no dest.
  - Any other opcode: dest=[11:8], src1=[7:4], src2=[3:0].
- Effective scoreboard: eff = busy_vec & ~(wb_valid ? onehot(wb_reg) : 0). A writeback in the current cycle frees the register for the same-cycle hazard check (write-through register file).
- inuse1 = uses_src1 & eff[src1]; inuse2 = uses_src2 & eff[src2]. Both 0 when dec_valid=0.
- hazard = inuse1 | inuse2 | (writes_dest & eff[dest]). The dest term is the WAW check.
- stall = dec_valid & ~flush & (hazard | ex_busy).
- issue = dec_valid & ~flush & ~stall.
- While rst=0, stall and issue are forced 0.
- ex_cnt is a 4-bit internal counter; ex_busy = (ex_cnt != 0).
  - On issue of MUL_OPCODE: ex_cnt <= MUL_LAT-1.
  - On issue of LOAD: ex_cnt <= MEM_LAT-1.
  - Otherwise, if nonzero: decrement.
  - Latency 1 gives zero occupancy.
  - Reload while nonzero cannot occur, because issue requires ex_busy=0.
- busy_vec next = eff | (issue & writes_dest ? onehot(dest) : 0).
  - Set wins over a same-cycle writeback of the same register.
  - wb_valid on a register that is not busy is a no-op.
- Flush: flush=1 sets busy_vec <= 0 and ex_cnt <= 0 on the next edge. Flush has priority over issue and writeback; no issue occurs in a flush cycle.
- Reset: rst low clears busy_vec=0, ex_cnt=0 (ex_busy=0) immediately, including mid-multiply. stall_cycles=0.
- No internal buffering: when stall=1 the upstream must hold dec_instr and dec_valid stable.

Optional Feature:
- Macro: STALL_STAT_EN.
- Defined:
  - stall_cycles increments every cycle stall=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined:
  - The stall_cycles port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then dec_valid=1, dec_instr=16'h2331 → issue=1, stall=0; next cycle busy_vec=16'h0008.
- Following 16'h2331, present 16'h4232 (src1=R3) → stall=1, inuse1=1, inuse2=0. Assert wb_valid=1, wb_reg=3 → same cycle issue=1; next cycle busy_vec=16'h0004.
- Issue 16'h3123 (MUL, MUL_LAT=3), then 16'h2456 → ex_busy=1 for 2 cycles and 16'h2456 stalls 2 cycles, issuing on the 3rd; busy_vec bit1 stays set until wb_reg=1.
- With busy_vec=16'h0080, issue LOAD 16'hE7E6 → issues (R7 not checked), busy_vec=16'h00C0. Then STORE 16'hF7E6 → stall=1, inuse1=1 until wb_reg=6.
- busy_vec=16'h00C0, ex_cnt=2, flush=1 with a hazard-free valid instruction → issue=0; next cycle busy_vec=0, ex_busy=0.
- rst low one cycle after MUL issue → busy_vec=0, ex_busy=0 without a clock edge. With STALL_STAT_EN, 5 stalled cycles beforehand read stall_cycles=5 before reset and 0 after.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - issue/hazard controller with register scoreboard (optional STALL_STAT_EN stall counter)
//
// Sits between fetch and decode. Tracks which registers have a pending
// write, raises inuse1/inuse2 for the decoder, and holds the front end
// whenever the presented instruction has a RAW/WAW hazard or the execute
// stage is still occupied by a multi-cycle multiply or load.
//
// Build option: define STALL_STAT_EN to add the stall_cycles counter port.

module issue_hazard_ctrl #(
  parameter logic [3:0] MUL_OPCODE = 4'b0011,
  parameter int         MUL_LAT    = 3,
  parameter int         MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [15:0] dec_instr,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic        inuse1,
  output logic        inuse2,
  output logic        ex_busy,
  output logic [15:0] busy_vec
`ifdef STALL_STAT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam logic [3:0] OP_LOAD  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1111;

  // Counter reload values: occupancy beyond the issue cycle itself.
  localparam logic [3:0] MUL_RELOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0] MEM_RELOAD = 4'(MEM_LAT - 1);

  logic [3:0]  op;
  logic [3:0]  dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        writes_dest;
  logic        uses_src1;
  logic        uses_src2;
  logic        is_mul;
  logic        is_load;

  logic [15:0] wb_mask;
  logic [15:0] eff;
  logic [15:0] set_mask;
  logic        hazard;
  logic        blocked;

  logic [3:0]  ex_cnt;

  assign op = dec_instr[15:12];

  // Field decode: LOAD and STORE keep their single register in [3:0].
  always_comb begin
    dest        = dec_instr[11:8];
    src1        = dec_instr[7:4];
    src2        = dec_instr[3:0];
    writes_dest = 1'b1;
    uses_src1   = 1'b1;
    uses_src2   = 1'b1;
    if (op == OP_LOAD) begin
      dest      = dec_instr[3:0];
      uses_src1 = 1'b0;
      uses_src2 = 1'b0;
    end else if (op == OP_STORE) begin
      src1        = dec_instr[3:0];
      uses_src2   = 1'b0;
      writes_dest = 1'b0;
    end
  end

  assign is_mul  = (op == MUL_OPCODE);
  assign is_load = (op == OP_LOAD);

  // A same-cycle writeback frees its register before the hazard check,
  // since the register file writes through to the operand read.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) begin
      wb_mask = 16'h0001 << wb_reg;
    end
    eff = busy_vec & ~wb_mask;
  end

  // Hazard detection and issue decision; reset forces both handshakes low.
  always_comb begin
    inuse1  = dec_valid & uses_src1 & eff[src1];
    inuse2  = dec_valid & uses_src2 & eff[src2];
    hazard  = inuse1 | inuse2 | (dec_valid & writes_dest & eff[dest]);
    blocked = hazard | ex_busy;
    stall   = rst & dec_valid & ~flush & blocked;
    issue   = rst & dec_valid & ~flush & ~blocked;
  end

  // Destination of an issuing instruction becomes pending.
  always_comb begin
    set_mask = '0;
    if (issue && writes_dest) begin
      set_mask = 16'h0001 << dest;
    end
  end

  // Scoreboard update: set wins over a same-cycle writeback of that register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec <= '0;
    end else if (flush) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= eff | set_mask;
    end
  end

  // Execute occupancy counter; a reload never meets a nonzero count because
  // nothing issues while the counter is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_cnt <= '0;
    end else if (flush) begin
      ex_cnt <= '0;
    end else if (issue && is_mul) begin
      ex_cnt <= MUL_RELOAD;
    end else if (issue && is_load) begin
      ex_cnt <= MEM_RELOAD;
    end else if (ex_cnt != 4'd0) begin
      ex_cnt <= ex_cnt - 4'd1;
    end
  end

  assign ex_busy = (ex_cnt != 4'd0);

`ifdef STALL_STAT_EN
  // Saturating count of stalled cycles; survives flush, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb/tb_issue_hazard_ctrl.sv - directed and randomized check of issue_hazard_ctrl against a behavioural model

module tb_issue_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int MEM_LAT = 2;
  localparam int MUL_OP  = 3;
  localparam int LOAD_OP = 14;
  localparam int STORE_OP = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid = 1'b0;
  logic [15:0] dec_instr = '0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        issue;
  logic        inuse1;
  logic        inuse2;
  logic        ex_busy;
  logic [15:0] busy_vec;
`ifdef STALL_STAT_EN
  logic [15:0] stall_cycles;
`endif

  issue_hazard_ctrl #(
    .MUL_OPCODE (4'b0011),
    .MUL_LAT    (MUL_LAT),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .flush     (flush),
    .stall     (stall),
    .issue     (issue),
    .inuse1    (inuse1),
    .inuse2    (inuse2),
    .ex_busy   (ex_busy),
    .busy_vec  (busy_vec)
`ifdef STALL_STAT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: set of registers awaiting writeback, and the cycle
  // number from which execute is free again.
  bit pend [16];
  int cyc       = 0;
  int ex_free_at = 0;
  int stall_cnt = 0;

  bit e_stall, e_issue, e_in1, e_in2, e_exb;
  bit m_writes;
  int m_dest, m_op;

  function automatic bit pending_now(input int r);
    return pend[r] && !(wb_valid && (int'(wb_reg) == r));
  endfunction

  function automatic logic [15:0] pend_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    ex_free_at = 0;
  endtask

  task automatic model_eval();
    int  op, d, s1, s2;
    bit  u1, u2, ud, haz;
    op = int'(dec_instr) / 4096;
    d  = (int'(dec_instr) / 256) % 16;
    s1 = (int'(dec_instr) / 16) % 16;
    s2 = int'(dec_instr) % 16;
    u1 = 1; u2 = 1; ud = 1;
    if (op == LOAD_OP) begin
      d = s2; u1 = 0; u2 = 0;
    end else if (op == STORE_OP) begin
      s1 = s2; u2 = 0; ud = 0;
    end
    e_exb   = (cyc < ex_free_at);
    e_in1   = dec_valid && u1 && pending_now(s1);
    e_in2   = dec_valid && u2 && pending_now(s2);
    haz     = e_in1 || e_in2 || (dec_valid && ud && pending_now(d));
    e_stall = rst && dec_valid && !flush && (haz || e_exb);
    e_issue = rst && dec_valid && !flush && !haz && !e_exb;
    m_writes = ud;
    m_dest   = d;
    m_op     = op;
  endtask

  task automatic model_commit();
    if (e_stall && stall_cnt < 65535) stall_cnt++;
    if (flush) begin
      model_clear();
    end else begin
      if (wb_valid) pend[wb_reg] = 1'b0;
      if (e_issue && m_writes) pend[m_dest] = 1'b1;
      if (e_issue && m_op == MUL_OP)  ex_free_at = cyc + MUL_LAT;
      if (e_issue && m_op == LOAD_OP) ex_free_at = cyc + MEM_LAT;
    end
    cyc++;
  endtask

  task automatic drive(input bit v, input logic [15:0] instr, input bit wv, input logic [3:0] wr, input bit fl);
    dec_valid = v;
    dec_instr = instr;
    wb_valid  = wv;
    wb_reg    = wr;
    flush     = fl;
  endtask

  // Called one time unit after a rising edge with inputs applied.
  task automatic step();
    #2;
    model_eval();
    check_eq("stall",    stall,    e_stall);
    check_eq("issue",    issue,    e_issue);
    check_eq("inuse1",   inuse1,   e_in1);
    check_eq("inuse2",   inuse2,   e_in2);
    check_eq("ex_busy",  ex_busy,  e_exb);
    check_eq("busy_vec", busy_vec, pend_vec());
`ifdef STALL_STAT_EN
    check_eq("stall_cycles", stall_cycles, stall_cnt);
`endif
    @(posedge clk);
    model_commit();
    #1;
  endtask

  bit prev_stall;

  initial begin
    model_clear();

    // Reset state, with a valid instruction that must not issue.
    drive(1, 16'h2331, 0, 0, 0);
    #3;
    check_eq("rst_busy", busy_vec, 16'h0000);
    check_eq("rst_exb", ex_busy, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_issue", issue, 1'b0);
    dec_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // RAW then same-cycle writeback release.
    drive(1, 16'h2331, 0, 0, 0);
    #1; check_eq("tp1_issue", issue, 1'b1);
    step();
    check_eq("tp1_busy", busy_vec, 16'h0008);
    drive(1, 16'h4232, 0, 0, 0);
    #1; check_eq("tp2_stall", stall, 1'b1); check_eq("tp2_in1", inuse1, 1'b1); check_eq("tp2_in2", inuse2, 1'b0);
    step();
    drive(1, 16'h4232, 1, 4'd3, 0);
    #1; check_eq("tp2_wb_issue", issue, 1'b1);
    step();
    check_eq("tp2_busy", busy_vec, 16'h0004);
    drive(0, 16'h0000, 1, 4'd2, 0);
    step();

    // Multiply occupancy.
    drive(1, 16'h3123, 0, 0, 0);
    step();
    drive(1, 16'h2456, 0, 0, 0);
    #1; check_eq("mul_stall1", stall, 1'b1); check_eq("mul_exb1", ex_busy, 1'b1);
    step();
    #1; check_eq("mul_stall2", stall, 1'b1);
    step();
    #1; check_eq("mul_issue3", issue, 1'b1);
    step();
    check_eq("mul_r1_held", busy_vec[1], 1'b1);
    drive(0, 16'h0000, 1, 4'd1, 0); step();
    drive(0, 16'h0000, 1, 4'd4, 0); step();

    // LOAD ignores R7, STORE waits on R6.
    drive(1, 16'h2700, 0, 0, 0); step();
    check_eq("ld_pre", busy_vec, 16'h0080);
    drive(1, 16'hE7E6, 0, 0, 0);
    #1; check_eq("ld_issue", issue, 1'b1);
    step();
    check_eq("ld_busy", busy_vec, 16'h00C0);
    drive(1, 16'hF7E6, 0, 0, 0);
    #1; check_eq("st_stall1", stall, 1'b1); check_eq("st_in1a", inuse1, 1'b1);
    step();
    #1; check_eq("st_stall2", stall, 1'b1); check_eq("st_in1b", inuse1, 1'b1);
    step();
    drive(1, 16'hF7E6, 1, 4'd6, 0);
    #1; check_eq("st_issue", issue, 1'b1);
    step();

    // Flush with busy scoreboard and running multiply.
    drive(1, 16'h3600, 0, 0, 0); step();
    check_eq("fl_pre", busy_vec, 16'h00C0);
    drive(1, 16'h2100, 0, 0, 1);
    #1; check_eq("fl_issue", issue, 1'b0);
    step();
    drive(0, 16'h0000, 0, 0, 0);
    #1; check_eq("fl_busy", busy_vec, 16'h0000); check_eq("fl_exb", ex_busy, 1'b0);
    step();

    // Five stalls, then async reset one cycle after a multiply issues.
    drive(1, 16'h2800, 0, 0, 0); step();
    drive(1, 16'h2080, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    drive(1, 16'h3123, 0, 0, 0); step();
    check_eq("ar_pre_exb", ex_busy, 1'b1);
`ifdef STALL_STAT_EN
    check_eq("ar_pre_stat", stall_cycles, stall_cnt);
`endif
    drive(1, 16'h2456, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_eq("ar_busy", busy_vec, 16'h0000);
    check_eq("ar_exb", ex_busy, 1'b0);
    check_eq("ar_stall", stall, 1'b0);
    check_eq("ar_issue", issue, 1'b0);
`ifdef STALL_STAT_EN
    check_eq("ar_stat", stall_cycles, 16'h0000);
`endif
    model_clear();
    stall_cnt = 0;
    dec_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic; a stalled instruction is held by upstream.
    prev_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!prev_stall) begin
        int sel;
        logic [15:0] ins;
        sel = $urandom_range(0, 9);
        ins = 16'($urandom);
        if (sel < 2)       ins[15:12] = 4'd3;
        else if (sel == 2) ins[15:12] = 4'hE;
        else if (sel == 3) ins[15:12] = 4'hF;
        dec_valid = ($urandom_range(0, 4) != 0);
        dec_instr = ins;
      end
      wb_valid = $urandom_range(0, 1);
      wb_reg   = 4'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 29) == 0);
      step();
      prev_stall = e_stall;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
